decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Buffered, parametrised decode stage for the RV64 pipeline, sitting between fetch and execute.
- Holds fetched instructions in a DEPTH-entry queue and decodes the head entry.
- Register operands are read through the register-file ports; the decoded result is registered into an output slot with a valid/ready handshake.
- Adds load-use hazard stalling and flush, both absent from the single-slot combinational decoder.

Parameters:
XLEN, 64, datapath/PC/immediate width
DEPTH, 4, queue entries (power of two, >=2)
RAW, 5, register address width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers {in_pc,in_instr}
in_ready  out  1  queue can accept
in_pc  in  XLEN  instruction PC
in_instr  in  32  raw instruction
flush  in  1  discard all queued/held instructions
ra1  out  RAW  regfile read addr 1 (head rs1)
ra2  out  RAW  regfile read addr 2 (head rs2)
rd1  in  XLEN  regfile data 1
rd2  in  XLEN  regfile data 2
ex_load_valid  in  1  execute stage holds a load
ex_dst  in  RAW  destination of that load
out_valid  out  1  decoded slot valid
out_ready  in  1  execute consumes slot
out_pc  out  XLEN  PC
out_instr  out  32  raw instruction
out_rs1  out  RAW  rs1 field (0 if unused)
out_rs2  out  RAW  rs2 field (0 if unused)
out_rd  out  RAW  rd field (0 if no writeback)
out_imm  out  XLEN  sign-extended immediate
out_srca  out  XLEN  rd1 captured
out_srcb  out  XLEN  rd2 captured
out_csr_addr  out  12  instr[31:20]
out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (resetn low, async): queue empty; count=0; out_valid=0; all out_* data outputs 0; in_ready=1 once released.
- Enqueue on rising edge when in_valid && in_ready && !flush.
- in_ready = (count < DEPTH). No same-cycle pass-through: when full, in_ready stays 0 even if a dequeue occurs.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Head decode is combinational. ra1 = head instr[19:15]; ra2 = head instr[24:20].
- Opcode classes, decided by instr[6:0]:
  - U (LUI 0110111, AUIPC 0010111): imm = {instr[31:12],12'b0} sign-extended.
  - J (1101111): imm = {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended.
  - I (JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, MISC-MEM 0001111, SYSTEM 1110011): imm = instr[31:20] sign-extended.
  - S (0100011): imm = {instr[31:25],instr[11:7]} sign-extended.
  - B (1100011): imm = {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended.
  - R (OP 0110011, OP-32 0111011): imm = 0.
  - Any other opcode: illegal=1, imm=0, rs1/rs2/rd=0.
- Register usage:
  - uses_rs1 for all classes except U and J.
  - uses_rs2 for S, B, R.
  - rd is written for all classes except S and B.
- Hazard = ex_load_valid && ex_dst!=0 && ((uses_rs1 && rs1==ex_dst) || (uses_rs2 && rs2==ex_dst)).
- Advance condition: head present && !hazard && (!out_valid || out_ready).
- On advance at an edge: head popped; out_* loaded with the decoded fields, srca=rd1, srcb=rd2; out_valid=1.
- If out_valid && out_ready and no advance: out_valid=0 (bubble).
- Decode latency: an instruction enqueued at edge k reaches the output slot at edge k+1 at the earliest.
- Throughput: 1 instruction/cycle when unstalled.
- Flush (sync, highest priority): at the edge, queue emptied, out_valid=0, the concurrent enqueue is dropped, and out_* data is held. in_ready=1 the next cycle.
- Simultaneous enqueue+advance: count unchanged, both pointers move.
- Reset asserted mid-operation: immediate return to the reset state; no partial state retained.

Optional Feature:
DECODE_QUEUE_PERF_EN
- Defined:
  - Adds output perf_hazard_cycles (32 bits), incremented each cycle the head is blocked only by hazard; saturates at 0xFFFFFFFF.
  - Adds output perf_full_cycles (32 bits), incremented each cycle in_valid && !in_ready; also saturating.
  - Both counters reset to 0 and are not cleared by flush.
- Not defined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Reset, then single ADDI x5,x1,-1 (0xFFF08293) at pc 0x80000000 with rd1=7 -> out_valid one edge after enqueue; out_rd=5, out_rs1=1, out_rs2=0, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_srca=7, out_illegal=0.
- out_ready=0, enqueue 5 instructions back-to-back -> in_ready drops after 4 queued + 1 in slot; raising out_ready drains them in order, one per cycle.
- ex_load_valid=1, ex_dst=3, head ADD x4,x3,x2 -> no advance, out_valid falls after consume. Drop ex_load_valid -> advances next edge. Perf build: perf_hazard_cycles equals the stalled cycles.
- ex_dst=0 with head using x0 -> no stall.
- BEQ 0xFE000EE3 -> out_imm=0xFFFF_FFFF_FFFF_FFFC, out_rd=0, out_rs2=0.
- Flush with 3 queued, out_valid=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1; the offered instruction never appears.
- Opcode 0x0000007F -> out_illegal=1, out_imm=0.
- resetn pulsed low mid-stream -> out_valid=0 immediately, queue empty.

Source files
------------

// File: rtl/decode_queue.sv
// Buffered RV64 decode stage: DEPTH-entry instruction queue, combinational head decode,
// registered output slot with load-use stall and flush. Optional counters: DECODE_QUEUE_PERF_EN.
module decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int RAW   = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic [RAW-1:0]  ra1,
  output logic [RAW-1:0]  ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            ex_load_valid,
  input  logic [RAW-1:0]  ex_dst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [RAW-1:0]  out_rs1,
  output logic [RAW-1:0]  out_rs2,
  output logic [RAW-1:0]  out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_srca,
  output logic [XLEN-1:0] out_srcb,
  output logic [11:0]     out_csr_addr,
  output logic            out_illegal
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_hazard_cycles,
  output logic [31:0]     perf_full_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            head_present;
  logic [6:0]      opcode;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_rd;
  logic            illegal;
  logic [XLEN-1:0] imm;
  logic [RAW-1:0]  dec_rs1;
  logic [RAW-1:0]  dec_rs2;
  logic [RAW-1:0]  dec_rd;
  logic            hazard;
  logic            advance;
  logic            push;

  assign in_ready     = (count < FULL_COUNT);
  assign head_present = (count != '0);
  assign head_pc      = pc_q[rd_ptr];
  assign head_instr   = instr_q[rd_ptr];
  assign opcode       = head_instr[6:0];
  assign ra1          = RAW'(head_instr[19:15]);
  assign ra2          = RAW'(head_instr[24:20]);

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    imm       = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
        imm = {{(XLEN-32){head_instr[31]}}, head_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        imm = {{(XLEN-21){head_instr[31]}}, head_instr[31], head_instr[19:12],
               head_instr[20], head_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_MISC_MEM, OPC_SYSTEM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm = {{(XLEN-12){head_instr[31]}}, head_instr[31:20]};
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm = {{(XLEN-12){head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm = {{(XLEN-13){head_instr[31]}}, head_instr[31], head_instr[7],
               head_instr[30:25], head_instr[11:8], 1'b0};
      end
      OPC_OP, OPC_OP32: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign dec_rs1 = uses_rs1  ? RAW'(head_instr[19:15]) : '0;
  assign dec_rs2 = uses_rs2  ? RAW'(head_instr[24:20]) : '0;
  assign dec_rd  = writes_rd ? RAW'(head_instr[11:7])  : '0;

  // x0 never carries a real load result, so a load to x0 cannot create a hazard.
  assign hazard  = ex_load_valid && (ex_dst != '0) &&
                   ((uses_rs1 && (dec_rs1 == ex_dst)) || (uses_rs2 && (dec_rs2 == ex_dst)));
  assign advance = head_present && !hazard && (!out_valid || out_ready);
  assign push    = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= in_pc;
        instr_q[wr_ptr] <= in_instr;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (advance) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, advance})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush only drops the valid bit; the slot's data fields keep their last values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_imm      <= '0;
      out_srca     <= '0;
      out_srcb     <= '0;
      out_csr_addr <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid    <= 1'b1;
      out_pc       <= head_pc;
      out_instr    <= head_instr;
      out_rs1      <= dec_rs1;
      out_rs2      <= dec_rs2;
      out_rd       <= dec_rd;
      out_imm      <= imm;
      out_srca     <= rd1;
      out_srcb     <= rd2;
      out_csr_addr <= head_instr[31:20];
      out_illegal  <= illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_QUEUE_PERF_EN
  // Counters saturate and survive flush so long runs stay meaningful.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_hazard_cycles <= '0;
      perf_full_cycles   <= '0;
    end else begin
      if (head_present && hazard && (!out_valid || out_ready) && (perf_hazard_cycles != '1)) begin
        perf_hazard_cycles <= perf_hazard_cycles + 1'b1;
      end
      if (in_valid && !in_ready && (perf_full_cycles != '1)) begin
        perf_full_cycles <= perf_full_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed instruction vectors with hand-decoded fields.
module tb_decode_queue;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic        ex_load_valid;
  logic [4:0]  ex_dst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [63:0] out_imm;
  logic [63:0] out_srca;
  logic [63:0] out_srcb;
  logic [11:0] out_csr_addr;
  logic        out_illegal;
`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] perf_hazard_cycles;
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_before;
`endif

  int          tests_run;
  int          tests_failed;
  exp_t        vec [10];
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [63:0] regs [32];

  decode_queue #(.XLEN(64), .DEPTH(4), .RAW(5)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .ex_load_valid(ex_load_valid), .ex_dst(ex_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_srca(out_srca), .out_srcb(out_srcb),
    .out_csr_addr(out_csr_addr), .out_illegal(out_illegal)
`ifdef DECODE_QUEUE_PERF_EN
    ,
    .perf_hazard_cycles(perf_hazard_cycles),
    .perf_full_cycles(perf_full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: fixed contents, x1 = 7 so the ADDI vector reads a known operand.
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'hA000_0000_0000_0000 | (64'(i) * 64'h111);
    regs[0] = 64'h0;
    regs[1] = 64'd7;
  end
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired, required finish before 500000");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    int  waited;
    bit  done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pc    = vec[idx].pc;
    in_instr = vec[idx].instr;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(vec[idx]);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL enqueue_timeout idx=%0d in_ready=%b required=1", idx, in_ready);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted output transfer is checked against the scoreboard head.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_output actual pc=%h instr=%h required=none", out_pc, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_pc", out_pc, mon_e.pc);
        checkOutput("out_instr", 64'(out_instr), 64'(mon_e.instr));
        checkOutput("out_rs1", 64'(out_rs1), 64'(mon_e.rs1));
        checkOutput("out_rs2", 64'(out_rs2), 64'(mon_e.rs2));
        checkOutput("out_rd", 64'(out_rd), 64'(mon_e.rd));
        checkOutput("out_imm", out_imm, mon_e.imm);
        checkOutput("out_srca", out_srca, regs[mon_e.instr[19:15]]);
        checkOutput("out_srcb", out_srcb, regs[mon_e.instr[24:20]]);
        checkOutput("out_csr_addr", 64'(out_csr_addr), 64'(mon_e.instr[31:20]));
        checkOutput("out_illegal", 64'(out_illegal), 64'(mon_e.illegal));
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vec[0] = '{64'h8000_0000, 32'hFFF08293, 5'd1, 5'd0, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vec[1] = '{64'h8000_0004, 32'hFFDFF0EF, 5'd0, 5'd0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vec[2] = '{64'h8000_0008, 32'h12345537, 5'd0, 5'd0, 5'd10, 64'h0000_0000_1234_5000, 1'b0};
    vec[3] = '{64'h8000_000C, 32'h80000537, 5'd0, 5'd0, 5'd10, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vec[4] = '{64'h8000_0010, 32'h0021A423, 5'd3, 5'd2, 5'd0,  64'd8,                  1'b0};
    vec[5] = '{64'h8000_0014, 32'h0103B303, 5'd7, 5'd0, 5'd6,  64'd16,                 1'b0};
    vec[6] = '{64'h8000_0018, 32'h00218233, 5'd3, 5'd2, 5'd4,  64'd0,                  1'b0};
    vec[7] = '{64'h8000_001C, 32'h00000233, 5'd0, 5'd0, 5'd4,  64'd0,                  1'b0};
    vec[8] = '{64'h8000_0020, 32'hFE000EE3, 5'd0, 5'd0, 5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vec[9] = '{64'h8000_0024, 32'h0000007F, 5'd0, 5'd0, 5'd0,  64'd0,                  1'b1};

    resetn        = 1'b0;
    in_valid      = 1'b0;
    in_pc         = '0;
    in_instr      = '0;
    flush         = 1'b0;
    ex_load_valid = 1'b0;
    ex_dst        = '0;
    out_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_pc", out_pc, 64'd0);
    checkOutput("reset_out_imm", out_imm, 64'd0);
    checkOutput("reset_out_srca", out_srca, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single ADDI with one-edge decode latency
    applyStimulus(0);
    @(negedge clk);
    checkOutput("latency_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("addi_bubble", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Fill four queue entries plus the output slot, then drain
    out_ready = 1'b0;
`ifdef DECODE_QUEUE_PERF_EN
    perf_before = perf_full_cycles;
`endif
    for (int i = 1; i <= 5; i++) applyStimulus(i);
    in_valid = 1'b1;
    in_pc    = 64'hBAD0_0000;
    in_instr = 32'hFFF08293;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("drain_valid", 64'(out_valid), 64'd1);
      if (i == 0) checkOutput("no_passthrough_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    checkOutput("drained_valid", 64'(out_valid), 64'd0);
    checkOutput("drained_in_ready", 64'(in_ready), 64'd1);
`ifdef DECODE_QUEUE_PERF_EN
    checkOutput("perf_full_cycles", 64'(perf_full_cycles - perf_before), 64'd2);
`endif
    @(posedge clk); #1;

    // Load-use hazard on rs1 = x3
    out_ready     = 1'b0;
    ex_load_valid = 1'b1;
    ex_dst        = 5'd3;
`ifdef DECODE_QUEUE_PERF_EN
    perf_before = perf_hazard_cycles;
`endif
    applyStimulus(5);
    applyStimulus(6);
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hazard_stall_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    ex_load_valid = 1'b0;
    @(negedge clk);
    checkOutput("hazard_release_wait", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("hazard_release_valid", 64'(out_valid), 64'd1);
`ifdef DECODE_QUEUE_PERF_EN
    checkOutput("perf_hazard_cycles", 64'(perf_hazard_cycles - perf_before), 64'd4);
`endif
    @(posedge clk); #1;

    // A load to x0 never stalls a head that reads x0
    ex_load_valid = 1'b1;
    ex_dst        = 5'd0;
    applyStimulus(7);
    @(negedge clk);
    checkOutput("x0_wait", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("x0_no_stall", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    ex_load_valid = 1'b0;
    applyStimulus(8);
    applyStimulus(9);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Flush with three queued, slot valid and a concurrent enqueue
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(i);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 64'hDEAD_0000;
    in_instr = 32'hFFF08293;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_data_held", out_pc, vec[1].pc);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("flush_empty", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    applyStimulus(8);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stream
    out_ready = 1'b0;
    applyStimulus(5);
    applyStimulus(6);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_pc", out_pc, 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midreset_empty", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    applyStimulus(0);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
